// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered result and zero flag, valid/ready handshake, optional iterative MUL.
// Optional feature macro: ALU_EXEC_MUL_EN (adds the shift-add multiplier on code 3).
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [4:0]        shamt_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SRAV = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd13;
    localparam logic [3:0] OP_LUI  = 4'd14;

    logic signed [DATA_W-1:0] src1_s;
    logic signed [DATA_W-1:0] src2_s;
    logic        [DATA_W-1:0] alu_res_p0;
    logic                     alu_legal_p0;
    logic                     accept;

    function automatic logic [DATA_W-1:0] sra_fn(input logic signed [DATA_W-1:0] v,
                                                 input logic [4:0] sh);
        logic signed [DATA_W-1:0] t;
        t = v >>> sh;
        return t;
    endfunction

    function automatic logic [DATA_W-1:0] flag_fn(input logic f);
        return {{(DATA_W-1){1'b0}}, f};
    endfunction

    assign src1_s = src1_i;
    assign src2_s = src2_i;
    assign accept = valid_i & ready_o;

    always_comb begin
        alu_res_p0   = '0;
        alu_legal_p0 = 1'b1;
        case (ctrl_i)
            OP_AND:  alu_res_p0 = src1_i & src2_i;
            OP_OR:   alu_res_p0 = src1_i | src2_i;
            OP_ADD:  alu_res_p0 = src1_i + src2_i;
            OP_SUB:  alu_res_p0 = src1_i - src2_i;
            OP_SLT:  alu_res_p0 = flag_fn(src1_s < src2_s);
            OP_SLTU: alu_res_p0 = flag_fn(src1_i < src2_i);
            OP_SRA:  alu_res_p0 = sra_fn(src2_s, shamt_i);
            OP_SRAV: alu_res_p0 = sra_fn(src2_s, src1_i[4:0]);
            OP_LUI:  alu_res_p0 = src2_i << 16;
            default: alu_legal_p0 = 1'b0;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mlier;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic              mul_start;

    assign ready_o   = (state == ST_IDLE);
    assign mul_start = accept && (ctrl_i == OP_MUL);
    assign acc_next  = acc + (mlier[0] ? mcand : '0);

    // multiplier datapath: no reset, only meaningful while state is ST_MUL
    always_ff @(posedge clk_i) begin
        if (mul_start) begin
            mcand <= src1_i;
            mlier <= src2_i;
            acc   <= '0;
        end else if (state == ST_MUL) begin
            mcand <= mcand << 1;
            mlier <= mlier >> 1;
            acc   <= acc_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            count    <= '0;
            result_o <= '0;
            zero_o   <= 1'b1;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mul_start) begin
                        state <= ST_MUL;
                        count <= '0;
                    end else if (accept) begin
                        done_o <= 1'b1;
                        if (alu_legal_p0) begin
                            result_o <= alu_res_p0;
                            zero_o   <= (alu_res_p0 == '0);
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    count <= count + CNT_W'(1);
                    // last iteration folds its partial product straight into the result
                    if (count == CNT_W'(DATA_W - 1)) begin
                        result_o <= acc_next;
                        zero_o   <= (acc_next == '0);
                        done_o   <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end
`else
    assign ready_o = 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o <= '0;
            zero_o   <= 1'b1;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            done_o <= accept;
            err_o  <= accept && !alu_legal_p0;
            if (accept && alu_legal_p0) begin
                result_o <= alu_res_p0;
                zero_o   <= (alu_res_p0 == '0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: behavioural model checked every cycle plus literal pins.
module tb_alu_exec_unit;
    localparam int DATA_W = 32;
`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  ctrl = 4'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic        ready;
    logic [31:0] result;
    logic        zero;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    alu_exec_unit #(.DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
        .ctrl_i(ctrl), .src1_i(src1), .src2_i(src2), .shamt_i(shamt),
        .result_o(result), .zero_o(zero), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the opcode table.
    function automatic bit model_legal(input logic [3:0] c);
        return (c == 4'd0 || c == 4'd1 || c == 4'd2 || c == 4'd6 || c == 4'd7 ||
                c == 4'd9 || c == 4'd11 || c == 4'd13 || c == 4'd14);
    endfunction

    function automatic logic [31:0] model_op(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] s);
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd13: return (a < b) ? 32'd1 : 32'd0;
            4'd9:  return $signed(b) >>> s;
            4'd11: return $signed(b) >>> a[4:0];
            4'd14: return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] m_result;
    logic        m_zero;
    logic        m_done;
    logic        m_err;
    logic [31:0] m_prod;
    int          m_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_result <= 32'd0;
            m_zero   <= 1'b1;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
            m_busy   <= 0;
            m_prod   <= 32'd0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_result <= m_prod;
                    m_zero   <= (m_prod == 32'd0);
                    m_done   <= 1'b1;
                end
            end else if (valid) begin
                if (MUL_EN && ctrl == 4'd3) begin
                    m_prod <= src1 * src2;
                    m_busy <= DATA_W;
                end else if (model_legal(ctrl)) begin
                    m_result <= model_op(ctrl, src1, src2, shamt);
                    m_zero   <= (model_op(ctrl, src1, src2, shamt) == 32'd0);
                    m_done   <= 1'b1;
                end else begin
                    m_done <= 1'b1;
                    m_err  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_result", result, m_result);
            check("cyc_zero", {31'd0, zero}, {31'd0, m_zero});
            check("cyc_done", {31'd0, done}, {31'd0, m_done});
            check("cyc_err", {31'd0, err}, {31'd0, m_err});
            check("cyc_ready", {31'd0, ready}, {31'd0, (m_busy == 0)});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Present an op and hold it until an edge accepts it; returns just after that edge's negedge.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s);
        bit got;
        got = 1'b0;
        valid = 1'b1; ctrl = c; src1 = a; src2 = b; shamt = s;
        for (int i = 0; i < 100 && !got; i++) begin
            got = ready;
            step();
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: ctrl %0d never accepted", c);
        end
    endtask

    initial begin
        int waited;
        #1 rst = 1'b1;
        step(); step();
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd1);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_zero", {31'd0, zero}, 32'd1);

        do_op(4'd2, 32'hFFFF_FFFF, 32'h1, 5'd0);
        check("add_wrap", result, 32'h0);
        check("add_zero", {31'd0, zero}, 32'd1);
        check("add_done", {31'd0, done}, 32'd1);
        do_op(4'd6, 32'd5, 32'd7, 5'd0);
        check("sub_neg", result, 32'hFFFF_FFFE);
        check("sub_zero", {31'd0, zero}, 32'd0);
        check("sub_done_b2b", {31'd0, done}, 32'd1);
        check("model_sub", m_result, 32'hFFFF_FFFE);
        do_op(4'd7, 32'hFFFF_FFFF, 32'h1, 5'd0);
        check("slt", result, 32'h1);
        do_op(4'd13, 32'hFFFF_FFFF, 32'h1, 5'd0);
        check("sltu", result, 32'h0);
        do_op(4'd9, 32'h0, 32'h8000_0000, 5'd4);
        check("sra", result, 32'hF800_0000);
        do_op(4'd11, 32'h21, 32'h8000_0000, 5'd0);
        check("srav", result, 32'hC000_0000);
        do_op(4'd14, 32'h0, 32'h1234, 5'd0);
        check("lui", result, 32'h1234_0000);
        do_op(4'd0, 32'hF0F0_FF00, 32'hFF00_F0F0, 5'd0);
        check("and", result, 32'hF000_F000);
        do_op(4'd1, 32'hF0F0_FF00, 32'hFF00_F0F0, 5'd0);
        check("or", result, 32'hFFF0_FFF0);
        do_op(4'd15, 32'h1, 32'h2, 5'd0);
        check("ill_hold", result, 32'hFFF0_FFF0);
        check("ill_done", {31'd0, done}, 32'd1);
        check("ill_err", {31'd0, err}, 32'd1);
        idle(1);
        check("ill_err_pulse", {31'd0, err}, 32'd0);

        if (MUL_EN) begin
            do_op(4'd3, 32'h0001_0003, 32'h0002_0005, 5'd0);
            valid = 1'b1; ctrl = 4'd2; src1 = 32'd2; src2 = 32'd3; shamt = 5'd0;
            waited = 0;
            while (!ready && waited < 100) begin
                step();
                waited++;
            end
            check("mul_stall_cycles", waited, 32'd32);
            check("mul_result", result, 32'h000B_000F);
            check("model_mul", m_result, 32'h000B_000F);
            check("mul_done", {31'd0, done}, 32'd1);
            step();
            check("held_add", result, 32'd5);
            idle(1);
            do_op(4'd3, 32'd7, 32'd9, 5'd0);
            valid = 1'b0;
            for (int i = 0; i < 10; i++) step();
            check("mul_busy", {31'd0, ready}, 32'd0);
        end else begin
            do_op(4'd3, 32'h0001_0003, 32'h0002_0005, 5'd0);
            check("mul_off_hold", result, 32'hFFF0_FFF0);
            check("mul_off_done", {31'd0, done}, 32'd1);
            check("mul_off_err", {31'd0, err}, 32'd1);
            do_op(4'd2, 32'd40, 32'd2, 5'd0);
            valid = 1'b0;
        end

        rst = 1'b1;
        #1;
        check("arst_result", result, 32'h0);
        check("arst_zero", {31'd0, zero}, 32'd1);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_ready", {31'd0, ready}, 32'd1);
        step();
        rst = 1'b0;
        idle(3);
        check("no_late_done", {31'd0, done}, 32'd0);
        do_op(4'd2, 32'd2, 32'd3, 5'd0);
        check("post_rst_add", result, 32'd5);
        idle(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit operation code produced by the ALU controller, plus two register operands and a shift amount. It returns a registered result with a zero flag. Single-cycle operations complete with 1-cycle latency at full throughput. MUL runs as an iterative shift-add sequence and stalls upstream through a valid/ready handshake until it finishes.

## Interface
- DATA_W, 32, operand/result width; MUL iteration count equals DATA_W
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  operation request
- ready_o  out  1  unit can accept; high exactly when FSM is IDLE
- ctrl_i  in  4  operation code from ALU controller
- src1_i  in  DATA_W  operand 1 (rs)
- src2_i  in  DATA_W  operand 2 (rt / immediate)
- shamt_i  in  5  instruction shift amount
- result_o  out  DATA_W  registered result
- zero_o  out  1  registered, result_o == 0
- done_o  out  1  one-cycle pulse: result_o/zero_o updated
- err_o  out  1  one-cycle pulse with done_o: illegal ctrl_i

## Operation
- Accept: rising edge with valid_i && ready_o; operands and ctrl_i captured on that edge only.
- Codes:
  - 0 AND, 1 OR, 2 ADD, 6 SUB: wrap modulo 2^DATA_W, no overflow flag.
  - 7 SLT: signed compare, result 1/0. 13 SLTU: unsigned compare, result 1/0.
  - 9 SRA: src2_i >>> shamt_i. 11 SRAV: src2_i >>> src1_i[4:0]. Both arithmetic, sign-filled.
  - 14 LUI: {src2_i[15:0], 16'b0}.
  - 3 MUL: low DATA_W bits of src1_i*src2_i; upper bits discarded.
- Illegal code (any other value): result_o and zero_o hold their previous values; done_o=1 and err_o=1 for one cycle.
- FSM states:
  - IDLE: ready_o=1. Accepting a non-MUL op updates result_o, zero_o and done_o, and the FSM stays in IDLE. Accepting a MUL loads the multiplicand, the multiplier, accumulator=0 and count=0, then moves to MUL.
  - MUL: ready_o=0. Each cycle: if the multiplier LSB is set, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; count+1. When count reaches DATA_W-1, write the accumulator to result_o, pulse done_o and go to IDLE.
- valid_i while ready_o=0 is ignored; upstream holds the request until it is accepted.
- Reset (any time, including mid-MUL): the in-progress MUL is aborted and discarded and the FSM goes to IDLE.
- Reset values: result_o=0, zero_o=1, done_o=0, err_o=0, ready_o=1, count=0.

## Timing
- Non-MUL: accept on edge E0; result_o, zero_o and done_o are valid in the cycle after E0 (latency 1). Back-to-back accepts are allowed every cycle, giving one done_o pulse per accepted op.
- MUL: accept on E0; iterations run on E1..E_DATA_W; result_o is written on E_DATA_W.
  - done_o and ready_o rise together in the following cycle, so the next op can be accepted on E_DATA_W+1.
  - Latency is DATA_W cycles; throughput is one MUL per DATA_W+1 cycles.
- done_o and err_o never stay high for two consecutive cycles unless two consecutive ops were accepted.
- result_o is stable from one done_o pulse until the next.

## Configuration
- ALU_EXEC_MUL_EN defined: MUL state and datapath are present; code 3 behaves as specified above.
- ALU_EXEC_MUL_EN undefined: no MUL state, accumulator or counter. Code 3 is treated as illegal (1-cycle done_o+err_o, result held), and ready_o is constant 1 outside reset.

## Test plan
- Reset then idle: result_o=0, zero_o=1, ready_o=1, done_o=0.
- ADD 0xFFFFFFFF+1 -> next cycle result_o=0, zero_o=1, done_o=1. Then SUB 5-7 on the immediately following cycle -> result_o=0xFFFFFFFE, zero_o=0.
- SLT src1=0xFFFFFFFF, src2=1 -> result_o=1. SLTU with the same operands -> result_o=0. SRA src2=0x80000000, shamt=4 -> 0xF8000000. SRAV src1=0x21, src2=0x80000000 -> 0xC0000000 (shift of 1). LUI src2=0x1234 -> 0x12340000.
- MUL 0x0001_0003 * 0x0002_0005 (MUL_EN) -> ready_o=0 for 32 cycles with valid_i held high, then result_o=0x000B_000F, done_o=1 and ready_o=1 in the same cycle, and the held op is accepted on the next edge.
- Assert rst_i at iteration 10 of a MUL -> outputs return to reset values immediately and no done_o pulse follows. After release, ADD 2+3 -> 5.
- ctrl_i=4'd15 -> done_o=1, err_o=1 and result_o unchanged. Without ALU_EXEC_MUL_EN, ctrl_i=3 gives the same response in 1 cycle.
